// File: rtl/bar_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : bar_ctrl_if
// Brief   : Button/vsync inputs and bar-height outputs of the bar_ctrl stage.
// Revision: 1.0 - initial release
// ============================================================================
interface bar_ctrl_if #(
    parameter int H_W = 8
);
    logic               btnU;
    logic               btnD;
    logic               btnL;
    logic               btnR;
    logic               vsync;
    logic [4*H_W-1:0]   heights;
    logic [1:0]         sel_lane;
    logic               frame_tick;

    modport master (
        output btnU, btnD, btnL, btnR, vsync,
        input  heights, sel_lane, frame_tick
    );

    modport slave (
        input  btnU, btnD, btnL, btnR, vsync,
        output heights, sel_lane, frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/bar_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : bar_ctrl
// Brief   : Debounced button control of four bar heights, updated per frame.
//           Optional BAR_CTRL_AUTODECAY_EN: non-selected lanes fall by 1/frame.
// Revision: 1.0 - initial release
// ============================================================================
module bar_ctrl #(
    parameter int H_W        = 8,
    parameter int MAX_H      = 240,
    parameter int INIT_H     = 16,
    parameter int STEP       = 8,
    parameter int DEB_CYCLES = 1000000
) (
    input  wire       clk,
    input  wire       btnC,
    bar_ctrl_if.slave bus
);

    localparam int c_CNT_W = $clog2(DEB_CYCLES + 1);
    localparam int c_EXT_W = H_W + 1;

    // Button order inside the vectors: 0=U, 1=D, 2=L, 3=R
    logic [3:0]     w_raw;
    logic [3:0]     w_deb;
    logic [3:0]     deb_prev_q;
    logic [1:0]     sel_q;
    logic [1:0]     sel_d;
    logic           vs_q;
    logic           tick_q;
    logic           w_frame;
    logic           w_rise_l;
    logic           w_rise_r;
    logic           w_up_only;
    logic           w_dn_only;
    logic [c_EXT_W-1:0] w_up;
    logic [c_EXT_W-1:0] w_dn;
    logic [H_W-1:0] h_q [4];
    logic [H_W-1:0] h_d [4];

    assign w_raw = {bus.btnR, bus.btnL, bus.btnD, bus.btnU};

    for (genvar b = 0; b < 4; b++) begin : g_btn
        logic [1:0]         sync_q;
        logic               stable_q;
        logic [c_CNT_W-1:0] cnt_q;

        always_ff @(posedge clk or posedge btnC) begin
            if (btnC) begin
                sync_q   <= 2'b00;
                stable_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                sync_q <= {sync_q[0], w_raw[b]};
                if (sync_q[1] == stable_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == c_CNT_W'(DEB_CYCLES - 1)) begin
                    // This sample is the DEB_CYCLES-th consecutive mismatch
                    stable_q <= ~stable_q;
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign w_deb[b] = stable_q;
    end

    assign w_rise_l  = w_deb[2] & ~deb_prev_q[2];
    assign w_rise_r  = w_deb[3] & ~deb_prev_q[3];
    assign w_frame   = bus.vsync & ~vs_q;
    assign w_up_only = w_deb[0] & ~w_deb[1];
    assign w_dn_only = w_deb[1] & ~w_deb[0];

    always_comb begin
        sel_d = sel_q;
        if (w_rise_r && !w_rise_l) begin
            sel_d = sel_q + 2'd1;
        end else if (w_rise_l && !w_rise_r) begin
            sel_d = sel_q - 2'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            h_d[i] = h_q[i];
        end
        // One bit wider so neither overflow past MAX_H nor underflow wraps
        w_up = {1'b0, h_q[sel_q]} + c_EXT_W'(STEP);
        w_dn = {1'b0, h_q[sel_q]} - c_EXT_W'(STEP);
        if (w_frame) begin
`ifdef BAR_CTRL_AUTODECAY_EN
            for (int i = 0; i < 4; i++) begin
                if ((2'(i) != sel_q) && (h_q[i] != '0)) begin
                    h_d[i] = h_q[i] - 1'b1;
                end
            end
`else
`endif
            if (w_up_only) begin
                h_d[sel_q] = (w_up > c_EXT_W'(MAX_H)) ? H_W'(MAX_H) : w_up[H_W-1:0];
            end else if (w_dn_only) begin
                h_d[sel_q] = w_dn[H_W] ? '0 : w_dn[H_W-1:0];
            end
        end
    end

    // Height update uses sel_q, i.e. the lane selected before any same-cycle change
    always_ff @(posedge clk or posedge btnC) begin
        if (btnC) begin
            deb_prev_q <= 4'b0000;
            sel_q      <= 2'd0;
            vs_q       <= 1'b1;
            tick_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                h_q[i] <= H_W'(INIT_H);
            end
        end else begin
            deb_prev_q <= w_deb;
            sel_q      <= sel_d;
            vs_q       <= bus.vsync;
            tick_q     <= w_frame;
            for (int i = 0; i < 4; i++) begin
                h_q[i] <= h_d[i];
            end
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_pack
        assign bus.heights[i*H_W +: H_W] = h_q[i];
    end

    assign bus.sel_lane   = sel_q;
    assign bus.frame_tick = tick_q;

endmodule
`default_nettype wire
